lock_key_loader: RTL and testbench
==================================

Name: lock_key_loader

Overview:
- Upstream stage that delivers the 32-bit unlock key to a locked combinational netlist; key_out drives that netlist's keyIn_0_0..keyIn_0_31 inputs directly (bit i to keyIn_0_i).
- Receives the key as a sequence of narrow words over a valid/ready handshake and assembles them into a shadow register.
- Publishes the key only when it is complete. At all other times it drives all-zero, so the locked netlist stays in its scrambled function.

Parameters:
KEY_WIDTH, 32, total key bits; must be an integer multiple of WORD_WIDTH
WORD_WIDTH, 8, bits accepted per handshake beat
TIMEOUT_CYCLES, 255, maximum idle cycles allowed between beats during a load before abort (1..65535)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
load_start  input  1  one-cycle pulse that begins a key load
key_clear  input  1  zeroize request
key_word  input  WORD_WIDTH  key data beat, least-significant word first
key_word_valid  input  1  key_word is valid
key_word_ready  output  1  loader accepts the beat this cycle
key_out  output  KEY_WIDTH  key to the locked netlist
key_valid  output  1  key_out holds a complete key
busy  output  1  load in progress
error  output  1  sticky abort flag

Behaviour:
- Reset: all outputs are 0. State is IDLE, the shadow register is 0, and the beat counter is 0. Reset asserted mid-load discards the partial key immediately (asynchronous).
- NWORDS = KEY_WIDTH/WORD_WIDTH. Beat counter width is clog2(NWORDS+1). Timeout counter width is clog2(TIMEOUT_CYCLES+1).
- States:
  - IDLE: waiting for a load.
  - LOAD: collecting beats.
  - READY: key complete and published.
- IDLE:
  - key_word_ready=0, busy=0.
  - load_start moves to LOAD and clears the shadow register, beat counter, timeout counter and error.
- LOAD:
  - busy=1, key_word_ready=1.
  - A beat is accepted when valid&&ready. Beat n writes shadow[n*WORD_WIDTH +: WORD_WIDTH], then the counter increments and the timeout counter resets.
  - Acceptance of beat NWORDS-1 moves to READY on the next edge. The beat accepted on that edge is included.
  - A cycle without a beat increments the timeout counter. When it reaches TIMEOUT_CYCLES, the loader sets error, zeroes the shadow register and returns to IDLE.
  - load_start in LOAD restarts the load: counter and shadow are cleared, any beat presented that cycle is ignored, and the state stays LOAD.
- READY:
  - key_valid=1, key_out=shadow, key_word_ready=0.
  - The key is held indefinitely.
  - load_start drops key_valid on the next edge and enters LOAD (reload).
- key_out equals shadow only in READY; it is all-zero in every other state. Partial keys are never visible.
- key_clear has priority over everything except rst. In any state it zeroes the shadow register and goes to IDLE next edge with key_valid=0, busy=0. error is left unchanged.
- key_clear and load_start in the same cycle: key_clear wins and load_start is ignored.
- Extra beats presented outside LOAD are not accepted (ready=0) and are dropped.
- error stays set until the next accepted load_start or rst.
- Latency: key_valid rises 1 cycle after the last beat is accepted. Minimum load time is NWORDS+1 cycles from load_start.

Optional Feature:
- Macro: LOCK_KEY_PARITY_CHECK_EN.
- Defined:
  - Adds input key_word_parity (1 bit), the even parity of key_word.
  - Each accepted beat is checked. On mismatch the loader sets error, zeroes the shadow register and returns to IDLE on the next edge; the beat is not written.
- Undefined:
  - The port does not exist and no check is performed.
  - error is set only by timeout.

Test Plan:
- Reset, then load_start, then 4 back-to-back beats 0xA5, 0x3C, 0xF0, 0x81:
  - key_valid=1 one cycle after the 4th beat.
  - key_out=0x81F03CA5.
  - busy falls on the same edge key_valid rises.
- During a load, stall after 2 beats with TIMEOUT_CYCLES=4:
  - After 4 idle cycles: error=1, state IDLE, key_out=0, key_valid=0.
  - A subsequent load_start clears error.
- In READY with key 0x81F03CA5, pulse load_start, load 0x11, 0x22, 0x33, 0x44:
  - key_valid=0 throughout the reload.
  - key_out=0 during the reload, then 0x44332211.
- After beat 3 of a load, assert key_clear and load_start together:
  - IDLE next cycle, key_out=0, busy=0.
  - The 4th beat presented afterwards is not accepted (ready=0).
- Assert rst asynchronously (between clock edges) in READY:
  - key_out=0, key_valid=0, error=0 immediately, without waiting for a clock edge.
  - A subsequent normal load succeeds.
- With LOCK_KEY_PARITY_CHECK_EN, send beat 0x07 with parity=0 (true parity 1) as beat 2:
  - error=1, IDLE, key_out=0.
  - Reload with correct parity yields the expected key.

Source files
------------

// File: rtl/lock_key_loader.sv
// rtl/lock_key_loader.sv - assembles a word-serial unlock key and publishes it only when complete.
// Optional beat parity checking is enabled by defining LOCK_KEY_PARITY_CHECK_EN.
module lock_key_loader #(
   parameter int KEY_WIDTH      = 32,
   parameter int WORD_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_start,
   input  logic                  key_clear,
   input  logic [WORD_WIDTH-1:0] key_word,
   input  logic                  key_word_valid,
`ifdef LOCK_KEY_PARITY_CHECK_EN
   input  logic                  key_word_parity,
`endif
   output logic                  key_word_ready,
   output logic [KEY_WIDTH-1:0]  key_out,
   output logic                  key_valid,
   output logic                  busy,
   output logic                  error
);

   localparam int NWORDS = KEY_WIDTH / WORD_WIDTH;
   localparam int CW     = $clog2(NWORDS + 1);
   localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_READY
   } state_t;

   state_t                 state_q, state_d;
   logic [KEY_WIDTH-1:0]   shadow_q, shadow_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [TW-1:0]          tmo_q, tmo_d;
   logic                   error_q, error_d;
   logic                   beat;
   logic                   par_ok;

`ifdef LOCK_KEY_PARITY_CHECK_EN
   assign par_ok = (key_word_parity == ^key_word);
`else
   assign par_ok = 1'b1;
`endif

   assign beat = key_word_valid && (state_q == ST_LOAD);

   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      cnt_d    = cnt_q;
      tmo_d    = tmo_q;
      error_d  = error_q;
      if (key_clear) begin
         // Zeroize wins over a simultaneous load_start; error is deliberately kept.
         state_d  = ST_IDLE;
         shadow_d = '0;
         cnt_d    = '0;
         tmo_d    = '0;
      end else if (load_start) begin
         state_d  = ST_LOAD;
         shadow_d = '0;
         cnt_d    = '0;
         tmo_d    = '0;
         error_d  = 1'b0;
      end else if (state_q == ST_LOAD) begin
         if (beat) begin
            if (!par_ok) begin
               state_d  = ST_IDLE;
               shadow_d = '0;
               error_d  = 1'b1;
            end else begin
               shadow_d[int'(cnt_q)*WORD_WIDTH +: WORD_WIDTH] = key_word;
               cnt_d = cnt_q + CW'(1);
               tmo_d = '0;
               if (cnt_q == CW'(NWORDS - 1)) begin
                  state_d = ST_READY;
               end
            end
         end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d  = ST_IDLE;
            shadow_d = '0;
            tmo_d    = '0;
            error_d  = 1'b1;
         end else begin
            tmo_d = tmo_q + TW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         shadow_q <= '0;
         cnt_q    <= '0;
         tmo_q    <= '0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         cnt_q    <= cnt_d;
         tmo_q    <= tmo_d;
         error_q  <= error_d;
      end
   end

   // Partial keys never reach the locked netlist.
   assign key_valid      = (state_q == ST_READY);
   assign key_out        = key_valid ? shadow_q : '0;
   assign busy           = (state_q == ST_LOAD);
   assign key_word_ready = (state_q == ST_LOAD);
   assign error          = error_q;

endmodule

// File: tb/tb_lock_key_loader.sv
// tb/tb_lock_key_loader.sv - scoreboard bench for lock_key_loader.
// Define LOCK_KEY_PARITY_CHECK_EN to also exercise the parity build.
module tb_lock_key_loader;

   localparam int KW  = 32;
   localparam int WW  = 8;
   localparam int TMO = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          load_start = 1'b0;
   logic          key_clear = 1'b0;
   logic [WW-1:0] key_word = '0;
   logic          key_word_valid = 1'b0;
`ifdef LOCK_KEY_PARITY_CHECK_EN
   logic          key_word_parity = 1'b0;
`endif
   logic          key_word_ready;
   logic [KW-1:0] key_out;
   logic          key_valid;
   logic          busy;
   logic          error;

   lock_key_loader #(.KEY_WIDTH(KW), .WORD_WIDTH(WW), .TIMEOUT_CYCLES(TMO)) dut (
      .clk            (clk),
      .rst            (rst),
      .load_start     (load_start),
      .key_clear      (key_clear),
      .key_word       (key_word),
      .key_word_valid (key_word_valid),
`ifdef LOCK_KEY_PARITY_CHECK_EN
      .key_word_parity(key_word_parity),
`endif
      .key_word_ready (key_word_ready),
      .key_out        (key_out),
      .key_valid      (key_valid),
      .busy           (busy),
      .error          (error)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_err;
      logic [31:0] key;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [WW-1:0] w);
      key_word       = w;
      key_word_valid = 1'b1;
`ifdef LOCK_KEY_PARITY_CHECK_EN
      key_word_parity = ^w;
`endif
      tick();
      key_word_valid = 1'b0;
   endtask

   task automatic pulse_start();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_error_cleared", 32'(error), 32'd0);
   endtask

   // Reference: a load whose every gap stays under TMO yields the key verbatim;
   // the first gap of TMO or more aborts with error and nothing published.
   task automatic load_key(input logic [31:0] key, input logic [3:0][3:0] gaps);
      exp_t e;
      int   abort_at;
      abort_at = -1;
      for (int i = 0; i < 4; i++) if (abort_at < 0 && int'(gaps[i]) >= TMO) abort_at = i;
      e.is_err = (abort_at >= 0);
      e.key    = key;
      exp_q.push_back(e);
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         if (i == abort_at) begin
            repeat (TMO - 1) tick();
            chk("pre_timeout_error", 32'(error), 32'd0);
            chk("pre_timeout_busy", 32'(busy), 32'd1);
            tick();
            chk("timeout_error", 32'(error), 32'd1);
            chk("timeout_busy", 32'(busy), 32'd0);
            chk("timeout_key_out", key_out, 32'd0);
            chk("timeout_key_valid", 32'(key_valid), 32'd0);
            return;
         end
         repeat (int'(gaps[i])) begin
            tick();
            chk("partial_hidden", key_out, 32'd0);
         end
         beat(key[i*WW +: WW]);
         if (i < 3) begin
            chk("partial_valid", 32'(key_valid), 32'd0);
            chk("partial_hidden", key_out, 32'd0);
         end
      end
      chk("done_valid", 32'(key_valid), 32'd1);
      chk("done_busy", 32'(busy), 32'd0);
      chk("done_key", key_out, key);
   endtask

   // Monitor: pops an expectation whenever key_valid or error rises.
   logic        prev_kv = 1'b0;
   logic        prev_err = 1'b0;
   logic [31:0] held_key = '0;
   always @(negedge clk) begin
      exp_t e;
      if (key_valid && !prev_kv) begin
         if (exp_q.size() == 0) chk("sb_unexpected_key", key_out, 32'd0);
         else begin
            e = exp_q.pop_front();
            chk("sb_kind_key", 32'(e.is_err), 32'd0);
            chk("sb_key", key_out, e.key);
         end
         held_key = key_out;
      end else if (key_valid) begin
         chk("sb_key_held", key_out, held_key);
      end
      if (error && !prev_err) begin
         if (exp_q.size() == 0) chk("sb_unexpected_error", 32'(error), 32'd0);
         else begin
            e = exp_q.pop_front();
            chk("sb_kind_error", 32'(e.is_err), 32'd1);
         end
      end
      if (!key_valid) chk("sb_out_zero", key_out, 32'd0);
      else chk("sb_ready_low", 32'(key_word_ready), 32'd0);
      prev_kv  = key_valid;
      prev_err = error;
   end

   initial begin
      logic [3:0][3:0] g;
      logic [31:0]     k;

      #1 rst = 1'b1;
      #1;
      chk("rst_key_out", key_out, 32'd0);
      chk("rst_key_valid", 32'(key_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_ready", 32'(key_word_ready), 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // Back-to-back load, then reload straight from READY.
      load_key(32'h81F03CA5, '0);
      tick();
      load_key(32'h44332211, '0);
      tick();

      // Stall after two beats until timeout, then a clean load.
      g = '0;
      g[2] = 4'(TMO);
      load_key(32'hDEADBEEF, g);
      tick();
      load_key(32'h12345678, '0);

      // Clear and start together after three beats.
      pulse_start();
      beat(8'hA5);
      beat(8'h3C);
      beat(8'hF0);
      key_clear  = 1'b1;
      load_start = 1'b1;
      tick();
      key_clear  = 1'b0;
      load_start = 1'b0;
      chk("clear_busy", 32'(busy), 32'd0);
      chk("clear_key_valid", 32'(key_valid), 32'd0);
      chk("clear_key_out", key_out, 32'd0);
      key_word       = 8'h81;
      key_word_valid = 1'b1;
      #1;
      chk("clear_stray_ready", 32'(key_word_ready), 32'd0);
      tick();
      key_word_valid = 1'b0;
      chk("clear_stray_busy", 32'(busy), 32'd0);

      // Asynchronous reset while READY.
      load_key(32'h81F03CA5, '0);
      tick();
      #3 rst = 1'b1;
      #1;
      chk("arst_key_out", key_out, 32'd0);
      chk("arst_key_valid", 32'(key_valid), 32'd0);
      chk("arst_error", 32'(error), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      load_key(32'hCAFEF00D, '0);
      tick();

`ifdef LOCK_KEY_PARITY_CHECK_EN
      begin
         exp_t e;
         e.is_err = 1'b1;
         e.key    = '0;
         exp_q.push_back(e);
         pulse_start();
         beat(8'h11);
         key_word        = 8'h07;
         key_word_parity = 1'b0;
         key_word_valid  = 1'b1;
         tick();
         key_word_valid = 1'b0;
         chk("parity_error", 32'(error), 32'd1);
         chk("parity_busy", 32'(busy), 32'd0);
         chk("parity_key_out", key_out, 32'd0);
         tick();
         load_key(32'h44330711, '0);
         tick();
      end
`endif

      // Randomized loads with occasional timeouts and stray beats outside LOAD.
      for (int n = 0; n < 40; n++) begin
         k = $urandom;
         for (int i = 0; i < 4; i++)
            g[i] = ($urandom_range(0, 9) == 0) ? 4'(TMO + $urandom_range(0, 2)) : 4'($urandom_range(0, TMO - 1));
         load_key(k, g);
         if ($urandom_range(0, 1) == 1) beat(8'($urandom));
         repeat ($urandom_range(0, 2)) tick();
      end

      tick();
      tick();
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
